// File: rtl/lock_sweep_ctrl_if.sv
// Report port of lock_sweep_ctrl: per-key mismatch summary over valid/ready.
// LOCK_SWEEP_FIRST_FAIL_EN adds the first-failing-vector capture fields.
interface lock_sweep_ctrl_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_VECT = 10000,
  parameter int NUM_KEYS = 16
);
  localparam int KA_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VI_W  = (NUM_VECT > 1) ? $clog2(NUM_VECT) : 1;
  localparam int ERR_W = $clog2(NUM_VECT + 1);
  localparam int BIT_W = $clog2(NUM_VECT * (DATA_W + 1) + 1);
  localparam int RES_W = DATA_W + 1;

  logic             res_valid_o;
  logic             res_ready_i;
  logic [KA_W-1:0]  res_key_idx_o;
  logic [ERR_W-1:0] res_err_cnt_o;
  logic [BIT_W-1:0] res_bit_cnt_o;
`ifdef LOCK_SWEEP_FIRST_FAIL_EN
  logic             res_ff_valid_o;
  logic [VI_W-1:0]  res_ff_idx_o;
  logic [RES_W-1:0] res_ff_xor_o;

  modport master (output res_valid_o, res_key_idx_o, res_err_cnt_o, res_bit_cnt_o,
                         res_ff_valid_o, res_ff_idx_o, res_ff_xor_o,
                  input  res_ready_i);
  modport slave  (input  res_valid_o, res_key_idx_o, res_err_cnt_o, res_bit_cnt_o,
                         res_ff_valid_o, res_ff_idx_o, res_ff_xor_o,
                  output res_ready_i);
`else
  modport master (output res_valid_o, res_key_idx_o, res_err_cnt_o, res_bit_cnt_o,
                  input  res_ready_i);
  modport slave  (input  res_valid_o, res_key_idx_o, res_err_cnt_o, res_bit_cnt_o,
                  output res_ready_i);
`endif
endinterface

// File: rtl/lock_sweep_ctrl.sv
// Key-sweep sequencer for the key-locked adder: for every key in the key table,
// streams NUM_VECT operand pairs into the adder, compares against a golden sum
// and reports mismatching vectors / bits per key on the report interface.
// Optional: LOCK_SWEEP_FIRST_FAIL_EN captures index and xor of the first
// mismatching vector of each key.
module lock_sweep_ctrl #(
  parameter int DATA_W   = 32,
  parameter int KEY_W    = 64,
  parameter int NUM_VECT = 10000,
  parameter int NUM_KEYS = 16,
  localparam int KA_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int VA_W    = $clog2(2 * NUM_VECT),
  localparam int RES_W   = DATA_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [KA_W-1:0]   key_addr_o,
  input  logic [KEY_W-1:0]  key_data_i,
  output logic [VA_W-1:0]   vec_addr_o,
  input  logic [DATA_W-1:0] vec_data_i,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o,
  output logic [KEY_W-1:0]  key_o,
  input  logic [RES_W-1:0]  result_i,
  output logic              busy_o,
  output logic              done_o,
  lock_sweep_ctrl_if.master res
);
  localparam int VI_W  = (NUM_VECT > 1) ? $clog2(NUM_VECT) : 1;
  localparam int ERR_W = $clog2(NUM_VECT + 1);
  localparam int BIT_W = $clog2(NUM_VECT * (DATA_W + 1) + 1);

  typedef enum logic [2:0] {IDLE, LDKEY, KWAIT, FA, FB, AP, CK, RPT_DONE_SPLIT} unused_t;
  typedef enum logic [3:0] {
    S_IDLE, S_LDKEY, S_KWAIT, S_FA, S_FB, S_AP, S_CK, S_RPT, S_DONE
  } state_t;

  state_t            state;
  logic [KA_W-1:0]   key_idx;
  logic [VI_W-1:0]   v_idx;
  logic [ERR_W-1:0]  err_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic              res_valid;

  logic [RES_W-1:0]  golden, x;
  logic [VI_W-1:0]   v_nxt;
  logic [KA_W-1:0]   k_nxt;
  logic              last_vec, last_key;

  // golden sum of the operands currently presented to the adder, and the error pattern
  assign golden   = {1'b0, a_reg} + {1'b0, b_reg};
  assign x        = result_i ^ golden;
  assign v_nxt    = v_idx + VI_W'(1);
  assign k_nxt    = key_idx + KA_W'(1);
  assign last_vec = (v_idx == VI_W'(NUM_VECT - 1));
  assign last_key = (key_idx == KA_W'(NUM_KEYS - 1));

`ifdef LOCK_SWEEP_FIRST_FAIL_EN
  logic             ff_valid;
  logic [VI_W-1:0]  ff_idx;
  logic [RES_W-1:0] ff_xor;
  assign res.res_ff_valid_o = ff_valid;
  assign res.res_ff_idx_o   = ff_idx;
  assign res.res_ff_xor_o   = ff_xor;
`endif

  assign res.res_valid_o   = res_valid;
  assign res.res_key_idx_o = key_idx;
  assign res.res_err_cnt_o = err_cnt;
  assign res.res_bit_cnt_o = bit_cnt;

  // Sweep FSM. Memory addresses are registered on entry to the state that
  // presents them, so read data lands in the following state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      key_idx    <= '0;
      v_idx      <= '0;
      err_cnt    <= '0;
      bit_cnt    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      key_addr_o <= '0;
      vec_addr_o <= '0;
      add1_o     <= '0;
      add2_o     <= '0;
      key_o      <= '0;
      res_valid  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef LOCK_SWEEP_FIRST_FAIL_EN
      ff_valid   <= 1'b0;
      ff_idx     <= '0;
      ff_xor     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        // abort beats every transition; DUT-facing operand/key regs hold
        state     <= S_IDLE;
        busy_o    <= 1'b0;
        res_valid <= 1'b0;
        key_idx   <= '0;
        v_idx     <= '0;
        err_cnt   <= '0;
        bit_cnt   <= '0;
`ifdef LOCK_SWEEP_FIRST_FAIL_EN
        ff_valid  <= 1'b0;
        ff_idx    <= '0;
        ff_xor    <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: if (start_i) begin
            key_idx    <= '0;
            v_idx      <= '0;
            err_cnt    <= '0;
            bit_cnt    <= '0;
            key_addr_o <= '0;
            busy_o     <= 1'b1;
            state      <= S_LDKEY;
`ifdef LOCK_SWEEP_FIRST_FAIL_EN
            ff_valid   <= 1'b0;
            ff_idx     <= '0;
            ff_xor     <= '0;
`endif
          end
          S_LDKEY: state <= S_KWAIT;
          S_KWAIT: begin
            key_o      <= key_data_i;
            vec_addr_o <= VA_W'({v_idx, 1'b0});
            state      <= S_FA;
          end
          S_FA: begin
            vec_addr_o <= VA_W'({v_idx, 1'b1});
            state      <= S_FB;
          end
          S_FB: begin
            a_reg <= vec_data_i;
            state <= S_AP;
          end
          S_AP: begin
            add1_o <= a_reg;
            add2_o <= vec_data_i;
            b_reg  <= vec_data_i;
            state  <= S_CK;
          end
          S_CK: begin
            if (x != '0) begin
              err_cnt <= err_cnt + ERR_W'(1);
              bit_cnt <= bit_cnt + BIT_W'($countones(x));
`ifdef LOCK_SWEEP_FIRST_FAIL_EN
              if (!ff_valid) begin
                ff_valid <= 1'b1;
                ff_idx   <= v_idx;
                ff_xor   <= x;
              end
`endif
            end
            if (last_vec) begin
              res_valid <= 1'b1;
              state     <= S_RPT;
            end else begin
              v_idx      <= v_nxt;
              vec_addr_o <= VA_W'({v_nxt, 1'b0});
              state      <= S_FA;
            end
          end
          S_RPT: if (res.res_ready_i) begin
            res_valid <= 1'b0;
            if (last_key) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              key_idx    <= k_nxt;
              key_addr_o <= k_nxt;
              v_idx      <= '0;
              err_cnt    <= '0;
              bit_cnt    <= '0;
              state      <= S_LDKEY;
`ifdef LOCK_SWEEP_FIRST_FAIL_EN
              ff_valid   <= 1'b0;
              ff_idx     <= '0;
              ff_xor     <= '0;
`endif
            end
          end
          S_DONE: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/lock_sweep_ctrl.md
Name: lock_sweep_ctrl

Overview:
- Sequencer for evaluating the key-locked 32-bit adder (two operands, 64-bit key, 33-bit result) under a sweep of candidate keys.
- For each key from a key table, streams operand pairs from a vector memory into the DUT and compares the DUT result to an internal golden sum.
- Reports per-key mismatch-vector and bit-error counts through a valid/ready result port.
- Replaces the open-loop stimulus loops in simulation.

Parameters:
- DATA_W, 32, operand width; result width is DATA_W+1.
- KEY_W, 64, key width.
- NUM_VECT, 10000, operand pairs per key; the vector memory holds 2*NUM_VECT words.
- NUM_KEYS, 16, entries in the key table.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  pulse that begins a sweep; ignored unless IDLE.
- abort_i  in  1  synchronous abort; return to IDLE.
- key_addr_o  out  clog2(NUM_KEYS)  key table address.
- key_data_i  in  KEY_W  key table data, valid 1 cycle after address.
- vec_addr_o  out  clog2(2*NUM_VECT)  vector memory address.
- vec_data_i  in  DATA_W  vector data, valid 1 cycle after address.
- add1_o  out  DATA_W  registered DUT operand A.
- add2_o  out  DATA_W  registered DUT operand B.
- key_o  out  KEY_W  registered DUT key.
- result_i  in  DATA_W+1  DUT result (combinational DUT).
- res_valid_o  out  1  per-key report valid.
- res_ready_i  in  1  report accepted.
- res_key_idx_o  out  clog2(NUM_KEYS)  key index being reported.
- res_err_cnt_o  out  clog2(NUM_VECT+1)  number of mismatching vectors.
- res_bit_cnt_o  out  clog2(NUM_VECT*(DATA_W+1)+1)  total mismatching result bits.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset: every output, counter and register is 0; state is IDLE.
- Golden value: {1'b0,a}+{1'b0,b}, DATA_W+1 bits, no truncation.
- All memory addresses are registered.
- States and transitions:
  - IDLE: on start_i, clear key_idx, v_idx and both counters, then go to LDKEY.
  - LDKEY: key_addr_o=key_idx; go to KWAIT.
  - KWAIT: key_o<=key_data_i; go to FA.
  - FA: vec_addr_o=2*v_idx; go to FB.
  - FB: vec_addr_o=2*v_idx+1; a_reg<=vec_data_i; go to AP.
  - AP: add1_o<=a_reg; add2_o<=vec_data_i; b_reg<=vec_data_i; go to CK.
  - CK: x=result_i^golden(a_reg,b_reg).
    - If x!=0, err_cnt+=1 and bit_cnt+=popcount(x).
    - If v_idx==NUM_VECT-1, go to RPT; otherwise v_idx+=1 and go to FA.
  - RPT: res_valid_o=1 with the res_* outputs stable; hold until res_ready_i is sampled high.
    - On the accept cycle, if key_idx==NUM_KEYS-1, go to DONE.
    - Otherwise key_idx+=1, clear v_idx and counters, and go to LDKEY.
  - DONE: done_o=1 for one cycle; go to IDLE.
- Throughput: 4 cycles per vector, plus 2 cycles per key load, plus report handshake cycles.
- res_valid_o rises only in RPT and never drops before acceptance.
- res_valid_o and res_ready_i high in the same cycle means accepted.
- abort_i has priority over every transition, including the RPT accept and the DONE pulse.
  - On abort: next state IDLE, res_valid_o=0, done_o=0, counters cleared.
  - key_o, add1_o and add2_o keep their last values.
- start_i asserted in the same cycle as abort_i: abort wins and start is ignored.
- Reset mid-sweep: immediate return to reset values; no report is emitted.
- Counters cannot overflow by construction of their widths.
- NUM_VECT==1 is legal: CK goes directly to RPT.

Optional Feature:
- Macro: LOCK_SWEEP_FIRST_FAIL_EN.
- Defined: adds outputs res_ff_valid_o (1), res_ff_idx_o (vector index width) and res_ff_xor_o (DATA_W+1).
  - Capture v_idx and x on the first mismatching CK of each key.
  - The captured values are presented with the report and cleared at key start.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Bench DUT model: result = a+b when key==64'h9634809C305E141C; otherwise result bit0 is inverted when a[0]&b[0].
- Key table entry 0 = 64'h9634809C305E141C, NUM_VECT=8, all vectors nonzero random -> report idx 0 with err_cnt=0, bit_cnt=0.
- Entry 1 = 64'h9634809C305E140C, 8 vectors of which exactly 3 have a[0]&b[0] -> err_cnt=3, bit_cnt=3; with the macro defined, ff_idx is the index of the first such vector.
- NUM_KEYS=2 with res_ready_i held low for 5 cycles in RPT -> res_valid_o held for 6 cycles with the outputs stable; done_o pulses exactly once after the second accept; busy_o then 0.
- abort_i asserted in CK of vector 4, key 0 -> IDLE the next cycle, no res_valid_o; a following start_i restarts at key 0, vector 0.
- rst_ni low during FB -> all outputs 0 immediately; start_i pulsed during busy -> ignored, and the sweep cycle count per key equals 4*NUM_VECT+2 plus handshake cycles.
